stopwatch_lap: RTL and testbench
================================

STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, count rate in Hz (1/100 s units).
REQ-003 SHALL have parameter LAP_DEPTH, default 4, number of lap registers (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_runstop  input  1  debounced one-cycle pulse, toggles run/stop.
REQ-007 SHALL have port i_clear  input  1  debounced one-cycle pulse, clear/reload.
REQ-008 SHALL have port i_lap  input  1  debounced one-cycle pulse, capture lap.
REQ-009 SHALL have port i_mode  input  1  0 = count up, 1 = count down; sampled only on clear.
REQ-010 SHALL have ports i_preset_min / i_preset_sec  input  6 each  countdown preset (0-59).
REQ-011 SHALL have port i_lap_sel  input  clog2(LAP_DEPTH)  lap register read index.
REQ-012 SHALL have ports msec 7 / sec 6 / min 6 / hour 5  output  live time.
REQ-013 SHALL have ports lap_msec 7 / lap_sec 6 / lap_min 6 / lap_hour 5  output  lap[i_lap_sel], combinational read.
REQ-014 SHALL have ports o_running 1, o_done 1, o_lap_full 1, o_lap_cnt clog2(LAP_DEPTH)+1  output  status.

Function
REQ-015 SHALL implement FSM states STOP, RUN, DONE; o_running=1 only in RUN.
REQ-016 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 only in RUN, emit one-cycle tick at terminal count, hold value in STOP/DONE, and zero on clear.
REQ-017 Up mode: per tick msec 0..99, carry to sec 0..59, min 0..59, hour 0..23; 23:59:59.99 wraps to 00:00:00.00, stays RUN.
REQ-018 Down mode: per tick decrement with borrow (msec 99, sec/min 59); reaching 00:00:00.00 SHALL enter DONE same cycle, o_done=1.
REQ-019 Time registers SHALL update the cycle after the tick (1-cycle latency).
REQ-020 STOP--i_runstop-->RUN; RUN--i_runstop-->STOP; i_runstop ignored in DONE; down mode with time 0 SHALL ignore i_runstop.
REQ-021 i_clear in any state SHALL go to STOP, zero prescaler, latch i_mode into internal mode register, empty lap buffer, clear o_done.
REQ-022 On clear: up mode loads 00:00:00.00; down mode loads hour 0, min=min(i_preset_min,59), sec=min(i_preset_sec,59), msec 0.
REQ-023 i_lap in RUN SHALL write current live time into lap[o_lap_cnt] and increment o_lap_cnt; ignored in STOP/DONE.
REQ-024 When o_lap_cnt==LAP_DEPTH, o_lap_full=1 and further i_lap SHALL be ignored (no overwrite).
REQ-025 Simultaneous pulses: i_clear beats i_runstop and i_lap; i_runstop+i_lap in RUN SHALL capture lap then stop.
REQ-026 Tick coinciding with i_runstop stop SHALL still apply that tick's count.
REQ-027 Unwritten lap entries and i_lap_sel>=o_lap_cnt SHALL read all zeros.

Reset
REQ-028 rst=0 at a clk edge SHALL force STOP, prescaler 0, all time and lap registers 0, o_lap_cnt 0, o_done 0, mode register 0 (up), overriding all inputs.
REQ-029 Reset mid-RUN SHALL take effect on that edge; counting resumes only after a new i_runstop.

Configuration
REQ-030 Macro STOPWATCH_COUNTDOWN_EN defined: down mode, presets, DONE state and o_done per REQ-018/022.
REQ-031 Macro undefined: mode register fixed 0, i_mode and presets ignored, DONE unreachable, o_done tied 0.

Verification (CLK_HZ=1000, TICK_HZ=100, divide-by-10)
REQ-032 Reset, i_runstop, wait 1000 clk -> time 00:00:01.00, o_running=1.
REQ-033 Preload up count near 23:59:59.99 (run 8,639,999 ticks or force) + 1 tick -> 00:00:00.00, still RUN.
REQ-034 i_mode=1, preset 0 min 1 s, i_clear, i_runstop, wait 1000 clk -> 00:00:00.00, state DONE, o_done=1; further i_runstop no effect.
REQ-035 Run, five i_lap pulses 100 clk apart -> lap0..3 = 00.10,00.20,00.30,00.40, o_lap_full=1, 5th ignored; lap_sel beyond count reads 0.
REQ-036 Same-cycle i_clear+i_runstop while RUN -> STOP, time 0, lap count 0; same-cycle i_runstop+i_lap -> lap captured, STOP.
REQ-037 rst=0 asserted mid-RUN for one edge -> all outputs 0, STOP; no count until next i_runstop.

Source files
------------

// File: rtl/stopwatch_lap.sv
// Stopwatch counting hh:mm:ss.cc with a lap capture buffer.
// Define STOPWATCH_COUNTDOWN_EN to add count-down mode, presets, the DONE state and o_done.
module stopwatch_lap #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int LAP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_runstop,
    input  logic                         i_clear,
    input  logic                         i_lap,
    input  logic                         i_mode,
    input  logic [5:0]                   i_preset_min,
    input  logic [5:0]                   i_preset_sec,
    input  logic [$clog2(LAP_DEPTH)-1:0] i_lap_sel,
    output logic [6:0]                   msec,
    output logic [5:0]                   sec,
    output logic [5:0]                   min,
    output logic [4:0]                   hour,
    output logic [6:0]                   lap_msec,
    output logic [5:0]                   lap_sec,
    output logic [5:0]                   lap_min,
    output logic [4:0]                   lap_hour,
    output logic                         o_running,
    output logic                         o_done,
    output logic                         o_lap_full,
    output logic [$clog2(LAP_DEPTH):0]   o_lap_cnt
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(LAP_DEPTH);
    localparam int CW  = SW + 1;

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] msec;
    } clk_time_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    clk_time_t       live_q, live_d;
    clk_time_t       lap_q [LAP_DEPTH];
    clk_time_t       lap_d [LAP_DEPTH];
    logic [CW-1:0]   lap_cnt_q, lap_cnt_d;

    logic            tick;
    logic            down_mode;
    logic            clear_down;
    logic            live_zero;
    logic            dec_zero;
    logic            lap_full;
    clk_time_t       inc_t;
    clk_time_t       dec_t;
    clk_time_t       preset_t;
    clk_time_t       lap_rd;

`ifdef STOPWATCH_COUNTDOWN_EN
    logic mode_q, mode_d;

    always_comb begin
        mode_d = mode_q;
        if (i_clear) begin
            mode_d = i_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign down_mode  = mode_q;
    assign clear_down = i_mode;
    assign o_done     = (state_q == ST_DONE);
`else
    logic unused_mode;

    assign unused_mode = i_mode;
    assign down_mode   = 1'b0;
    assign clear_down  = 1'b0;
    assign o_done      = 1'b0;
`endif

    assign tick      = (state_q == ST_RUN) && (presc_q == PW'(DIV - 1));
    assign live_zero = (live_q == '0);
    assign dec_zero  = (dec_t == '0);
    assign lap_full  = (lap_cnt_q == CW'(LAP_DEPTH));

    always_comb begin
        preset_t      = '0;
        preset_t.min  = (i_preset_min > 6'd59) ? 6'd59 : i_preset_min;
        preset_t.sec  = (i_preset_sec > 6'd59) ? 6'd59 : i_preset_sec;
    end

    // Carry chain for count-up; 23:59:59.99 rolls back to all zeros.
    always_comb begin
        inc_t = live_q;
        if (live_q.msec != 7'd99) begin
            inc_t.msec = live_q.msec + 7'd1;
        end else begin
            inc_t.msec = '0;
            if (live_q.sec != 6'd59) begin
                inc_t.sec = live_q.sec + 6'd1;
            end else begin
                inc_t.sec = '0;
                if (live_q.min != 6'd59) begin
                    inc_t.min = live_q.min + 6'd1;
                end else begin
                    inc_t.min  = '0;
                    inc_t.hour = (live_q.hour == 5'd23) ? 5'd0 : live_q.hour + 5'd1;
                end
            end
        end
    end

    // Borrow chain for count-down; never evaluated at zero because RUN leaves at zero.
    always_comb begin
        dec_t = live_q;
        if (live_q.msec != 7'd0) begin
            dec_t.msec = live_q.msec - 7'd1;
        end else begin
            dec_t.msec = 7'd99;
            if (live_q.sec != 6'd0) begin
                dec_t.sec = live_q.sec - 6'd1;
            end else begin
                dec_t.sec = 6'd59;
                if (live_q.min != 6'd0) begin
                    dec_t.min = live_q.min - 6'd1;
                end else begin
                    dec_t.min  = 6'd59;
                    dec_t.hour = live_q.hour - 5'd1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        live_d    = live_q;
        lap_d     = lap_q;
        lap_cnt_d = lap_cnt_q;

        if (i_clear) begin
            state_d   = ST_STOP;
            presc_d   = '0;
            lap_cnt_d = '0;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                lap_d[i] = '0;
            end
            live_d = clear_down ? preset_t : '0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (i_runstop && !(down_mode && live_zero)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        live_d = down_mode ? dec_t : inc_t;
                    end
                    // The lap records the time shown before this cycle's tick lands.
                    if (i_lap && !lap_full) begin
                        for (int i = 0; i < LAP_DEPTH; i++) begin
                            if (lap_cnt_q == CW'(i)) begin
                                lap_d[i] = live_q;
                            end
                        end
                        lap_cnt_d = lap_cnt_q + 1'b1;
                    end
                    if (tick && down_mode && dec_zero) begin
                        state_d = ST_DONE;
                    end else if (i_runstop) begin
                        state_d = ST_STOP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_STOP;
            presc_q   <= '0;
            live_q    <= '0;
            lap_cnt_q <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                lap_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            live_q    <= live_d;
            lap_cnt_q <= lap_cnt_d;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                lap_q[i] <= lap_d[i];
            end
        end
    end

    assign lap_rd = ({1'b0, i_lap_sel} < lap_cnt_q) ? lap_q[i_lap_sel] : '0;

    assign msec       = live_q.msec;
    assign sec        = live_q.sec;
    assign min        = live_q.min;
    assign hour       = live_q.hour;
    assign lap_msec   = lap_rd.msec;
    assign lap_sec    = lap_rd.sec;
    assign lap_min    = lap_rd.min;
    assign lap_hour   = lap_rd.hour;
    assign o_running  = (state_q == ST_RUN);
    assign o_lap_full = lap_full;
    assign o_lap_cnt  = lap_cnt_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Self-checking bench for stopwatch_lap: directed scenarios plus a randomized run
// checked against a centisecond-count reference model.
module tb_stopwatch_lap;

    localparam int CLK_HZ    = 1000;
    localparam int TICK_HZ   = 100;
    localparam int LAP_DEPTH = 4;
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int DAY_CS    = 24 * 60 * 60 * 100;
`ifdef STOPWATCH_COUNTDOWN_EN
    localparam bit COUNTDOWN = 1'b1;
`else
    localparam bit COUNTDOWN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_runstop = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_lap = 1'b0;
    logic       i_mode = 1'b0;
    logic [5:0] i_preset_min = '0;
    logic [5:0] i_preset_sec = '0;
    logic [1:0] i_lap_sel = '0;
    logic [6:0] msec, lap_msec;
    logic [5:0] sec, min, lap_sec, lap_min;
    logic [4:0] hour, lap_hour;
    logic       o_running, o_done, o_lap_full;
    logic [2:0] o_lap_cnt;
    logic [23:0] live_obs, lap_obs;

    int checks = 0;
    int errors = 0;

    int m_cs = 0;
    int m_presc = 0;
    bit m_run = 0;
    bit m_done = 0;
    bit m_mode = 0;
    int m_cnt = 0;
    int m_lap [LAP_DEPTH];

    stopwatch_lap #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .LAP_DEPTH(LAP_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_runstop   (i_runstop),
        .i_clear     (i_clear),
        .i_lap       (i_lap),
        .i_mode      (i_mode),
        .i_preset_min(i_preset_min),
        .i_preset_sec(i_preset_sec),
        .i_lap_sel   (i_lap_sel),
        .msec        (msec),
        .sec         (sec),
        .min         (min),
        .hour        (hour),
        .lap_msec    (lap_msec),
        .lap_sec     (lap_sec),
        .lap_min     (lap_min),
        .lap_hour    (lap_hour),
        .o_running   (o_running),
        .o_done      (o_done),
        .o_lap_full  (o_lap_full),
        .o_lap_cnt   (o_lap_cnt)
    );

    always #5 clk = ~clk;

    assign live_obs = {hour, min, sec, msec};
    assign lap_obs  = {lap_hour, lap_min, lap_sec, lap_msec};

    function automatic logic [23:0] pack(input int cs);
        return {5'(cs / 360000), 6'((cs / 6000) % 60), 6'((cs / 100) % 60), 7'(cs % 100)};
    endfunction

    function automatic string fmt(input logic [23:0] t);
        return $sformatf("%0d:%0d:%0d.%0d", t[23:19], t[18:13], t[12:7], t[6:0]);
    endfunction

    function automatic int clamp59(input logic [5:0] v);
        return (v > 6'd59) ? 59 : int'(v);
    endfunction

    // Reference model: time is one integer of centiseconds, advanced per spec rules.
    task automatic model_edge(input bit rs, input bit clr, input bit lp);
        bit tick;
        if (!rst) begin
            m_cs = 0; m_presc = 0; m_run = 0; m_done = 0; m_mode = 0; m_cnt = 0;
            foreach (m_lap[i]) m_lap[i] = 0;
        end else if (clr) begin
            m_run = 0; m_done = 0; m_presc = 0; m_cnt = 0;
            foreach (m_lap[i]) m_lap[i] = 0;
            m_mode = COUNTDOWN && i_mode;
            m_cs = m_mode ? (clamp59(i_preset_min) * 60 + clamp59(i_preset_sec)) * 100 : 0;
        end else if (m_run) begin
            tick = (m_presc == DIV - 1);
            m_presc = tick ? 0 : m_presc + 1;
            if (lp && m_cnt < LAP_DEPTH) begin
                m_lap[m_cnt] = m_cs;
                m_cnt++;
            end
            if (tick) m_cs = m_mode ? m_cs - 1 : (m_cs + 1) % DAY_CS;
            if (tick && m_mode && m_cs == 0) begin
                m_run = 0;
                m_done = 1;
            end else if (rs) begin
                m_run = 0;
            end
        end else if (!m_done && rs && !(m_mode && m_cs == 0)) begin
            m_run = 1;
        end
    endtask

    task automatic step(input bit rs, input bit clr, input bit lp);
        i_runstop = rs;
        i_clear   = clr;
        i_lap     = lp;
        @(posedge clk);
        model_edge(rs, clr, lp);
        #1;
        i_runstop = 1'b0;
        i_clear   = 1'b0;
        i_lap     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(1, 1, 1);
        rst = 1'b1;
        checks++;
        if (live_obs !== 24'd0) begin
            errors++;
            $display("[TB] FAIL reset_time: got %s expected 0:0:0.0", fmt(live_obs));
        end
        checks++;
        if ({o_running, o_done, o_lap_full, o_lap_cnt} !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_status: got %b expected 000000", {o_running, o_done, o_lap_full, o_lap_cnt});
        end
    endtask

    task automatic test_count_up();
        i_mode = 1'b0;
        step(0, 1, 0);
        step(1, 0, 0);
        repeat (1000) step(0, 0, 0);
        checks++;
        if (live_obs !== pack(100)) begin
            errors++;
            $display("[TB] FAIL up_1s: got %s expected 0:0:1.0", fmt(live_obs));
        end
        checks++;
        if (o_running !== 1'b1) begin
            errors++;
            $display("[TB] FAIL up_running: got %b expected 1", o_running);
        end
        step(0, 1, 0);
        step(1, 0, 0);
        repeat (9) step(0, 0, 0);
        step(1, 0, 0);
        repeat (30) step(0, 0, 0);
        checks++;
        if (live_obs !== pack(1) || o_running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_on_tick: got %s run=%b expected 0:0:0.1 run=0", fmt(live_obs), o_running);
        end
    endtask

    task automatic test_laps();
        step(0, 1, 0);
        step(1, 0, 0);
        repeat (5) begin
            repeat (100) step(0, 0, 0);
            step(0, 0, 1);
        end
        checks++;
        if (o_lap_cnt !== 3'd4 || o_lap_full !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lap_full: got cnt=%0d full=%b expected cnt=4 full=1", o_lap_cnt, o_lap_full);
        end
        for (int k = 0; k < LAP_DEPTH; k++) begin
            i_lap_sel = 2'(k);
            #1;
            checks++;
            if (lap_obs !== pack(10 * (k + 1))) begin
                errors++;
                $display("[TB] FAIL lap%0d: got %s expected %s", k, fmt(lap_obs), fmt(pack(10 * (k + 1))));
            end
        end
        step(0, 1, 0);
        step(1, 0, 0);
        repeat (20) step(0, 0, 0);
        step(0, 0, 1);
        for (int k = 0; k < LAP_DEPTH; k++) begin
            i_lap_sel = 2'(k);
            #1;
            checks++;
            if (lap_obs !== ((k == 0) ? pack(2) : 24'd0)) begin
                errors++;
                $display("[TB] FAIL lap_sel%0d_partial: got %s expected %s", k, fmt(lap_obs), fmt((k == 0) ? pack(2) : 24'd0));
            end
        end
    endtask

    task automatic test_simultaneous();
        step(1, 1, 0);
        checks++;
        if (live_obs !== 24'd0 || o_running !== 1'b0 || o_lap_cnt !== 3'd0) begin
            errors++;
            $display("[TB] FAIL clear_beats_run: got %s run=%b cnt=%0d expected 0:0:0.0 run=0 cnt=0", fmt(live_obs), o_running, o_lap_cnt);
        end
        step(1, 0, 0);
        repeat (35) step(0, 0, 0);
        step(1, 0, 1);
        i_lap_sel = 2'd0;
        #1;
        checks++;
        if (o_running !== 1'b0 || o_lap_cnt !== 3'd1 || lap_obs !== pack(3)) begin
            errors++;
            $display("[TB] FAIL lap_and_stop: got run=%b cnt=%0d lap=%s expected run=0 cnt=1 lap=0:0:0.3", o_running, o_lap_cnt, fmt(lap_obs));
        end
    endtask

    task automatic test_countdown();
`ifdef STOPWATCH_COUNTDOWN_EN
        i_mode = 1'b1; i_preset_min = 6'd0; i_preset_sec = 6'd1;
        step(0, 1, 0);
        checks++;
        if (live_obs !== pack(100) || o_running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL down_load: got %s run=%b expected 0:0:1.0 run=0", fmt(live_obs), o_running);
        end
        step(1, 0, 0);
        repeat (1000) step(0, 0, 0);
        checks++;
        if (live_obs !== 24'd0 || o_done !== 1'b1 || o_running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL down_done: got %s done=%b run=%b expected 0:0:0.0 done=1 run=0", fmt(live_obs), o_done, o_running);
        end
        step(1, 0, 0);
        repeat (20) step(0, 0, 0);
        checks++;
        if (o_done !== 1'b1 || o_running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_ignores_run: got done=%b run=%b expected done=1 run=0", o_done, o_running);
        end
        i_preset_min = 6'd63; i_preset_sec = 6'd61;
        step(0, 1, 0);
        checks++;
        if (live_obs !== pack(359900) || o_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL preset_clamp: got %s done=%b expected 0:59:59.0 done=0", fmt(live_obs), o_done);
        end
        i_preset_min = 6'd0; i_preset_sec = 6'd0;
        step(0, 1, 0);
        step(1, 0, 0);
        checks++;
        if (o_running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_preset_run: got run=%b expected 0", o_running);
        end
`else
        i_mode = 1'b1; i_preset_min = 6'd5; i_preset_sec = 6'd5;
        step(0, 1, 0);
        checks++;
        if (live_obs !== 24'd0) begin
            errors++;
            $display("[TB] FAIL mode_ignored_load: got %s expected 0:0:0.0", fmt(live_obs));
        end
        step(1, 0, 0);
        repeat (20) step(0, 0, 0);
        checks++;
        if (live_obs !== pack(2) || o_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mode_ignored_up: got %s done=%b expected 0:0:0.2 done=0", fmt(live_obs), o_done);
        end
`endif
        i_mode = 1'b0; i_preset_min = 6'd0; i_preset_sec = 6'd0;
    endtask

    task automatic test_reset_midrun();
        step(0, 1, 0);
        step(1, 0, 0);
        repeat (30) step(0, 0, 0);
        step(0, 0, 1);
        repeat (26) step(0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0);
        rst = 1'b1;
        checks++;
        if (live_obs !== 24'd0 || {o_running, o_done, o_lap_full, o_lap_cnt} !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_midrun: got %s status=%b expected zeros", fmt(live_obs), {o_running, o_done, o_lap_full, o_lap_cnt});
        end
        repeat (50) step(0, 0, 0);
        checks++;
        if (live_obs !== 24'd0 || o_running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_resume: got %s run=%b expected 0:0:0.0 run=0", fmt(live_obs), o_running);
        end
        step(1, 0, 0);
        repeat (10) step(0, 0, 0);
        checks++;
        if (live_obs !== pack(1)) begin
            errors++;
            $display("[TB] FAIL reset_restart: got %s expected 0:0:0.1", fmt(live_obs));
        end
    endtask

    task automatic test_random();
        logic [23:0] exp_lap;
        bit rs, clr, lp;
        for (int c = 0; c < 4000; c++) begin
            rs  = ($urandom % 40) == 0;
            clr = ($urandom % 150) == 0;
            lp  = ($urandom % 25) == 0;
            if (clr) begin
                i_mode       = 1'($urandom % 2);
                i_preset_sec = 6'($urandom % 4);
                i_preset_min = (($urandom % 8) == 0) ? 6'($urandom_range(55, 63)) : 6'd0;
            end
            i_lap_sel = 2'($urandom % 4);
            rst = (($urandom % 700) == 0) ? 1'b0 : 1'b1;
            step(rs, clr, lp);
            rst = 1'b1;
            checks++;
            if (live_obs !== pack(m_cs)) begin
                errors++;
                $display("[TB] FAIL rand_time cyc %0d: got %s expected %s", c, fmt(live_obs), fmt(pack(m_cs)));
            end
            checks++;
            if ({o_running, o_done, o_lap_full, o_lap_cnt} !== {m_run, m_done, m_cnt == LAP_DEPTH, 3'(m_cnt)}) begin
                errors++;
                $display("[TB] FAIL rand_status cyc %0d: got %b expected %b", c, {o_running, o_done, o_lap_full, o_lap_cnt}, {m_run, m_done, m_cnt == LAP_DEPTH, 3'(m_cnt)});
            end
            exp_lap = (int'(i_lap_sel) < m_cnt) ? pack(m_lap[i_lap_sel]) : 24'd0;
            checks++;
            if (lap_obs !== exp_lap) begin
                errors++;
                $display("[TB] FAIL rand_lap cyc %0d sel %0d: got %s expected %s", c, i_lap_sel, fmt(lap_obs), fmt(exp_lap));
            end
        end
    endtask

    initial begin
        $display("[TB] stopwatch_lap bench start, countdown=%0d", COUNTDOWN);
        test_reset();
        test_count_up();
        test_laps();
        test_simultaneous();
        test_countdown();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
